synapse_mac: RTL and testbench
==============================

SYNAPSE_MAC -- requirements
Module: synapse_mac

Interface
REQ-001 SHALL have parameter NUM_IN, default 16, meaning the number of presynaptic inputs per neuron.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the unsigned output sum width that feeds the neuron body.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8, meaning the signed two's-complement weight width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: a spike frame is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a frame.
REQ-008 SHALL have port in_spikes, input, NUM_IN bits: presynaptic spike vector; bit i belongs to synapse i.
REQ-009 SHALL have port w_we, input, 1 bit: weight write enable.
REQ-010 SHALL have port w_addr, input, clog2(NUM_IN) bits: index of the weight to write.
REQ-011 SHALL have port w_data, input, WEIGHT_WIDTH bits: signed weight value.
REQ-012 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-013 SHALL have port out_mac_sum, output, DATA_WIDTH bits: clamped weighted sum, held until the next result.
REQ-014 SHALL have port out_busy, output, 1 bit: high while a frame is being accumulated.

Function
REQ-015 SHALL use two states: IDLE and ACCUM.
REQ-016 SHALL drive in_ready=1 in IDLE and in_ready=0 in ACCUM; in_ready SHALL not depend combinationally on in_valid.
REQ-017 SHALL, on a handshake at cycle T (in_valid & in_ready), latch in_spikes, clear the accumulator and index, and enter ACCUM at T+1.
REQ-018 SHALL, in ACCUM, process one synapse per cycle for index 0..NUM_IN-1: acc += in_spikes[idx] ? sign-extended w[idx] : 0.
REQ-019 SHALL size the accumulator at ACC_W = WEIGHT_WIDTH + clog2(NUM_IN) + 1 bits, signed, so that it never overflows.
REQ-020 SHALL, on the cycle idx = NUM_IN-1, register clamp(acc + last term, 0, 2^DATA_WIDTH-1) into out_mac_sum, set out_valid for the next cycle only, and return to IDLE.
REQ-021 SHALL give a latency of exactly NUM_IN+1 cycles: out_valid is high at T+NUM_IN+1, and in_ready is high in that same cycle.
REQ-022 SHALL support back-to-back operation: a handshake in the out_valid cycle starts the next frame with no bubble.
REQ-023 SHALL ignore in_valid and in_spikes while in ACCUM; changes to in_spikes after the handshake SHALL not affect the result.
REQ-024 SHALL accept weight writes in any state, taking effect on the next cycle.
REQ-025 SHALL, for a write to the index being processed in the same cycle, use the old weight.
REQ-026 SHALL, for a write to an already-processed index, affect only later frames.
REQ-027 SHALL produce out_mac_sum = 0 with the normal latency for an all-zero in_spikes frame.
REQ-028 SHALL drive out_busy = (state == ACCUM).

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=IDLE, acc=0, idx=0, all weights=0, out_mac_sum=0, out_valid=0 and out_busy=0; in_ready SHALL be 1 on the first cycle after reset.
REQ-030 SHALL abort a frame on reset asserted mid-ACCUM, with no out_valid pulse for that frame.
REQ-031 SHALL give rst priority over w_we in the same cycle.

Structure
REQ-032 SHALL place the state encoding (IDLE=1'b0, ACCUM=1'b1) and the ACC_W derivation in the shared package snn_pkg, alongside the neuron-stage constants.
REQ-033 SHALL hold the weights in one sub-module, synapse_weight_rf: NUM_IN x WEIGHT_WIDTH registers, one synchronous write port, one combinational read port indexed by idx, synchronous reset to 0.

Verification
REQ-034 SHALL cover: all weights = 10, in_spikes = 16'h000F -> out_valid at T+17, out_mac_sum = 40.
REQ-035 SHALL cover: all weights = 127, in_spikes = 16'hFFFF -> raw sum 2032 -> out_mac_sum = 255.
REQ-036 SHALL cover: w[0] = w[1] = -50, w[2] = 20, in_spikes = 16'h0007 -> raw sum -80 -> out_mac_sum = 0.
REQ-037 SHALL cover: in_valid held high with frames 16'h0001 then 16'h0003 (all weights 5) -> in_ready low for 16 cycles; results 5 at T+17 and 10 at T+34; no bubble between frames.
REQ-038 SHALL cover: w_we to address 4, new value 100 (old 10), in the cycle idx = 4, in_spikes = 16'h0010 -> out_mac_sum = 10; the next frame gives 100.
REQ-039 SHALL cover: rst pulsed at T+8 of a frame -> no out_valid; out_mac_sum = 0; in_ready = 1 on the first cycle after reset; all weights read back as 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron pipeline stages.
// Holds the synapse MAC state encoding and the accumulator width rule.
package snn_pkg;

    localparam int SNN_NUM_IN       = 16;
    localparam int SNN_DATA_WIDTH   = 8;
    localparam int SNN_WEIGHT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } mac_state_t;

    // One extra bit per doubling of inputs plus a sign bit keeps the signed sum exact.
    function automatic int calc_acc_w(input int weight_w, input int num_in);
        return weight_w + $clog2(num_in) + 1;
    endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// Per-synapse signed weight registers: one synchronous write port,
// one combinational read port, synchronous clear on reset.
module synapse_weight_rf
    import snn_pkg::*;
#(
    parameter int NUM_IN       = SNN_NUM_IN,
    parameter int WEIGHT_WIDTH = SNN_WEIGHT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [$clog2(NUM_IN)-1:0] i_waddr,
    input  logic [WEIGHT_WIDTH-1:0]   i_wdata,
    input  logic [$clog2(NUM_IN)-1:0] i_raddr,
    output logic [WEIGHT_WIDTH-1:0]   o_rdata
);

    logic [WEIGHT_WIDTH-1:0] r_mem [NUM_IN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < NUM_IN)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A same-cycle write is not visible here until the next cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/synapse_mac.sv
// Serial synapse multiply-accumulate: one spike-gated weight per cycle,
// clamped to an unsigned neuron-body input.
module synapse_mac
    import snn_pkg::*;
#(
    parameter int NUM_IN       = SNN_NUM_IN,
    parameter int DATA_WIDTH   = SNN_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = SNN_WEIGHT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN-1:0]         in_spikes,
    input  logic                      w_we,
    input  logic [$clog2(NUM_IN)-1:0] w_addr,
    input  logic [WEIGHT_WIDTH-1:0]   w_data,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_mac_sum,
    output logic                      out_busy
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int ACC_W = calc_acc_w(WEIGHT_WIDTH, NUM_IN);
    localparam int EXT_W = ACC_W + DATA_WIDTH + 1;
    localparam logic signed [EXT_W-1:0] SUM_MAX =
        {{(EXT_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    // Handshake: a frame transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready is a pure function of the registered state.
    mac_state_t                r_state;
    logic [NUM_IN-1:0]         r_spikes;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]     r_sum;
    logic                      r_valid;

    logic [WEIGHT_WIDTH-1:0]   w_weight;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [EXT_W-1:0]   w_acc_ext;
    logic [DATA_WIDTH-1:0]     w_clamped;
    logic                      w_last;

    synapse_weight_rf #(
        .NUM_IN       (NUM_IN),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_weights (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_addr),
        .i_wdata (w_data),
        .i_raddr (r_idx),
        .o_rdata (w_weight)
    );

    assign w_term     = r_spikes[r_idx]
                      ? {{(ACC_W-WEIGHT_WIDTH){w_weight[WEIGHT_WIDTH-1]}}, w_weight}
                      : '0;
    assign w_acc_next = r_acc + w_term;
    assign w_acc_ext  = {{(EXT_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    assign w_last     = (r_idx == IDX_W'(NUM_IN - 1));

    always_comb begin
        w_clamped = w_acc_ext[DATA_WIDTH-1:0];
        if (w_acc_ext[EXT_W-1]) begin
            w_clamped = '0;
        end else if (w_acc_ext > SUM_MAX) begin
            w_clamped = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_spikes <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_sum    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_spikes <= in_spikes;
                        r_idx    <= '0;
                        r_acc    <= '0;
                        r_state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_sum   <= w_clamped;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_busy    = (r_state == ST_ACCUM);
    assign out_valid   = r_valid;
    assign out_mac_sum = r_sum;

endmodule

// File: tb/tb_synapse_mac.sv
// Directed bench for synapse_mac: frames push expected sums and result
// cycles into a scoreboard; a monitor pops and compares on out_valid.
module tb_synapse_mac;

    localparam int NUM_IN = 16;
    localparam int LAT    = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_spikes;
    logic        w_we;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic        out_valid;
    logic [7:0]  out_mac_sum;
    logic        out_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_hs = 0;
    int busy_run = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];

    synapse_mac #(
        .NUM_IN       (16),
        .DATA_WIDTH   (8),
        .WEIGHT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_spikes   (in_spikes),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .out_valid   (out_valid),
        .out_mac_sum (out_mac_sum),
        .out_busy    (out_busy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_mac_sum", int'(out_mac_sum), int'(exp_q.pop_front()));
                check("out_valid_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    // busy-window monitor: every completed frame keeps in_ready low for NUM_IN cycles
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            check("busy_vs_ready", int'(out_busy), int'(!in_ready));
            if (!in_ready) begin
                busy_run++;
            end else begin
                if (busy_run != 0) check("in_ready_low_cycles", busy_run, NUM_IN);
                busy_run = 0;
            end
        end
    end

    // driver tasks (called at posedge + 1)
    task automatic write_w(input logic [3:0] a, input logic [7:0] d);
        w_we   = 1'b1;
        w_addr = a;
        w_data = d;
        @(posedge clk);
        #1;
        w_we   = 1'b0;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < NUM_IN; i++) write_w(4'(i), v);
    endtask

    task automatic send(input logic [15:0] sp, input logic [7:0] exp,
                        input bit push, input bit hold);
        int k;
        bit ok;
        in_valid  = 1'b1;
        in_spikes = sp;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 100) begin
            @(negedge clk);
            ok = in_ready;
            k++;
        end
        if (!ok) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        last_hs = cyc;
        if (push) begin
            exp_q.push_back(exp);
            exp_cyc_q.push_back(cyc + LAT);
        end
        in_spikes = 16'($urandom);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) check("result_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int hs1;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_spikes = '0;
        w_we      = 1'b1;
        w_addr    = 4'd0;
        w_data    = 8'd50;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        w_we = 1'b0;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_busy", int'(out_busy), 0);
        check("reset_out_mac_sum", int'(out_mac_sum), 0);

        // reset beat the concurrent write to w[0]
        send(16'h0001, 8'd0, 1, 0);
        wait_done();

        set_all(8'd10);
        send(16'h000F, 8'd40, 1, 0);
        wait_done();

        set_all(8'd127);
        send(16'hFFFF, 8'd255, 1, 0);
        send(16'h0000, 8'd0, 1, 0);
        wait_done();

        write_w(4'd0, 8'(-50));
        write_w(4'd1, 8'(-50));
        write_w(4'd2, 8'd20);
        send(16'h0007, 8'd0, 1, 0);
        wait_done();

        // exact top of range and just above it
        set_all(8'd17);
        send(16'h7FFF, 8'd255, 1, 0);
        send(16'hFFFF, 8'd255, 1, 0);
        set_all(8'd16);
        send(16'h7FFF, 8'd240, 1, 0);
        wait_done();

        // mixed signs: w[i] = 10*i - 60, odd synapses -> 640 - 480
        for (int i = 0; i < NUM_IN; i++) write_w(4'(i), 8'(i * 10 - 60));
        send(16'hAAAA, 8'd160, 1, 0);
        wait_done();

        // back-to-back frames with in_valid held high
        set_all(8'd5);
        send(16'h0001, 8'd5, 1, 1);
        hs1 = last_hs;
        send(16'h0003, 8'd10, 1, 0);
        check("back_to_back_gap", last_hs - hs1, LAT + 1);
        wait_done();

        // write to the index being processed uses the old weight
        set_all(8'd10);
        send(16'h0010, 8'd10, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        write_w(4'd4, 8'd100);
        wait_done();
        send(16'h0010, 8'd100, 1, 0);
        wait_done();

        // reset mid-frame: no result, everything cleared
        set_all(8'd10);
        send(16'hFFFF, 8'd0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_busy", int'(out_busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_mac_sum", int'(out_mac_sum), 0);
        repeat (20) @(posedge clk);
        #1;
        send(16'hFFFF, 8'd0, 1, 0);
        wait_done();
        write_w(4'd3, 8'd7);
        send(16'h0008, 8'd7, 1, 0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
